// File: rtl/fibo_pkg.sv
// ----------------------------------------------------------------------------
// fibo_pkg
// Shared definitions for the Fibonacci LED pattern generator and its helpers.
//   mode_e      : run-mode encodings driven on the generator's mode input
//   clog2_min1  : ceil(log2(value)) with a floor of one bit, for counters
//                 whose terminal value may be zero
// ----------------------------------------------------------------------------
package fibo_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP   = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_HOLD   = 2'b10,
      MODE_STEP   = 2'b11
   } mode_e;

   function automatic int clog2_min1(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/fibo_seq_gen_tick_div.sv
// ----------------------------------------------------------------------------
// tick_div
// Free-running clock divider shared by the LED pattern blocks. The counter
// runs 0..DIV-1 and wraps; pulse is high during the cycle the counter sits
// at DIV-1, so one pulse is produced every DIV clocks.
//   clk   : system clock
//   reset : synchronous, active-high; counter to 0
//   clr   : synchronous clear; counter held at 0 while high
//   pulse : high for one clock out of every DIV (always high when DIV=1)
// ----------------------------------------------------------------------------
module tick_div
   import fibo_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic pulse
);

   localparam int            CW   = clog2_min1(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pulse = (cnt_q == LAST);

endmodule

// File: rtl/fibo_seq_gen.sv
// ----------------------------------------------------------------------------
// fibo_seq_gen
// Fibonacci pattern generator for LEDs / display drivers. Holds the pair
// (F(n), F(n+1)) and advances forward or backward through the sequence,
// either at a decimated rate (run modes) or on explicit step requests.
//   clk     : system clock
//   reset   : synchronous, active-high
//   mode    : 00 run-wrap, 01 run-bounce, 10 hold, 11 single-step
//   step    : advance request, used only in single-step mode
//   restart : synchronous return to F(0); same effect as reset
//   out     : current value F(n)
//   dir     : 0 forward, 1 reverse
//   tick    : one-clock pulse with every advance
//   wrap    : one-clock pulse on a wrap to 0 or a bounce turnaround
// All outputs are registers; there is no combinational input-to-output path.
// ----------------------------------------------------------------------------
module fibo_seq_gen
   import fibo_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DECIMATION = 1000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             step,
   input  logic             restart,
   output logic [WIDTH-1:0] out,
   output logic             dir,
   output logic             tick,
   output logic             wrap
);

   localparam logic [WIDTH:0] FB_INIT = {{WIDTH{1'b0}}, 1'b1};

   mode_e mode_s;
   logic  run_mode;
   logic  div_pulse;
   logic  adv;

   // fa is F(n); fb is F(n+1), one bit wider so the out-of-range successor
   // can be detected instead of silently truncated.
   logic [WIDTH-1:0] fa_q, fa_d;
   logic [WIDTH:0]   fb_q, fb_d;
   logic             dir_q, dir_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;

   logic [WIDTH:0]   fwd_sum;
   logic [WIDTH:0]   rev_diff;

   assign mode_s   = mode_e'(mode);
   assign run_mode = (mode_s == MODE_WRAP) || (mode_s == MODE_BOUNCE);

   // The divider is parked at zero outside run modes, so re-entering a run
   // mode always waits a full DECIMATION period before the first advance.
   tick_div #(
      .DIV   (DECIMATION)
   ) u_tick_div (
      .clk   (clk),
      .reset (reset),
      .clr   (restart | ~run_mode),
      .pulse (div_pulse)
   );

   always_comb begin
      adv = 1'b0;
      case (mode_s)
         MODE_WRAP, MODE_BOUNCE: adv = div_pulse;
         MODE_STEP:              adv = step;
         default:                adv = 1'b0;
      endcase
   end

   // Both neighbours of the current pair; only one is used per advance.
   assign fwd_sum  = {1'b0, fa_q} + fb_q;
   assign rev_diff = fb_q - {1'b0, fa_q};

   always_comb begin
      fa_d   = fa_q;
      fb_d   = fb_q;
      dir_d  = dir_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      if (restart) begin
         fa_d  = '0;
         fb_d  = FB_INIT;
         dir_d = 1'b0;
      end else if (adv) begin
         tick_d = 1'b1;
         if (!dir_q) begin
            if (!fb_q[WIDTH]) begin
               fa_d = fb_q[WIDTH-1:0];
               fb_d = fwd_sum;
            end else if (mode_s == MODE_BOUNCE) begin
               // Top turnaround: flip and take the reverse step right away
               // so the peak value is not shown twice.
               dir_d  = 1'b1;
               wrap_d = 1'b1;
               fa_d   = rev_diff[WIDTH-1:0];
               fb_d   = {1'b0, fa_q};
            end else begin
               fa_d   = '0;
               fb_d   = FB_INIT;
               wrap_d = 1'b1;
            end
         end else begin
            if (fa_q != '0) begin
               fa_d = rev_diff[WIDTH-1:0];
               fb_d = {1'b0, fa_q};
            end else begin
               // Bottom turnaround: (0,1) steps forward to (1,1).
               dir_d  = 1'b0;
               wrap_d = 1'b1;
               fa_d   = fb_q[WIDTH-1:0];
               fb_d   = fwd_sum;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fa_q   <= '0;
         fb_q   <= FB_INIT;
         dir_q  <= 1'b0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         fa_q   <= fa_d;
         fb_q   <= fb_d;
         dir_q  <= dir_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   assign out  = fa_q;
   assign dir  = dir_q;
   assign tick = tick_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_fibo_seq_gen.sv
// ----------------------------------------------------------------------------
// tb_fibo_seq_gen
// Directed bench for fibo_seq_gen. A main instance (WIDTH=8, DECIMATION=20)
// covers run-wrap, run-bounce, hold, single-step and restart; two corner
// instances (WIDTH=2 and WIDTH=16, both DECIMATION=1) cover narrow/wide
// sequences and an advance on every clock. Expected values come from an
// index-based Fibonacci model and are queued when stimulus is applied.
// ----------------------------------------------------------------------------
module tb_fibo_seq_gen;

   typedef struct {
      logic [63:0] val;
      logic        dir;
      logic        wrap;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [1:0]  mode;
   logic        step;
   logic        restart;
   logic [7:0]  out8;
   logic        dir8, tick8, wrap8;

   logic        reset_c;
   logic [1:0]  mode_c;
   logic        step_c;
   logic        restart_c;
   logic [1:0]  out2;
   logic        dir2, tick2, wrap2;
   logic [15:0] out16;
   logic        dir16, tick16, wrap16;

   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];
   int   m_n;
   logic m_dir;

   fibo_seq_gen #(.WIDTH(8), .DECIMATION(20)) dut8 (
      .clk(clk), .reset(reset), .mode(mode), .step(step), .restart(restart),
      .out(out8), .dir(dir8), .tick(tick8), .wrap(wrap8)
   );

   fibo_seq_gen #(.WIDTH(2), .DECIMATION(1)) dut2 (
      .clk(clk), .reset(reset_c), .mode(mode_c), .step(step_c), .restart(restart_c),
      .out(out2), .dir(dir2), .tick(tick2), .wrap(wrap2)
   );

   fibo_seq_gen #(.WIDTH(16), .DECIMATION(1)) dut16 (
      .clk(clk), .reset(reset_c), .mode(mode_c), .step(step_c), .restart(restart_c),
      .out(out16), .dir(dir16), .tick(tick16), .wrap(wrap16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=time_limit required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] fibv(input int n);
      logic [63:0] a = 64'd0;
      logic [63:0] b = 64'd1;
      logic [63:0] t;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   task automatic model_reset();
      m_n   = 0;
      m_dir = 1'b0;
   endtask

   // One advance of the reference: position index n and direction.
   task automatic model_adv(input int w, input logic [1:0] md, output exp_t e);
      e.wrap = 1'b0;
      if (!m_dir) begin
         if (fibv(m_n + 1) < (64'd1 << w)) begin
            m_n = m_n + 1;
         end else if (md == 2'b01) begin
            m_dir  = 1'b1;
            m_n    = m_n - 1;
            e.wrap = 1'b1;
         end else begin
            m_n    = 0;
            e.wrap = 1'b1;
         end
      end else begin
         if (m_n != 0) begin
            m_n = m_n - 1;
         end else begin
            m_dir  = 1'b0;
            m_n    = 1;
            e.wrap = 1'b1;
         end
      end
      e.val = fibv(m_n);
      e.dir = m_dir;
   endtask

   task automatic push_adv(input int w, input logic [1:0] md, input int cnt);
      exp_t e;
      for (int i = 0; i < cnt; i++) begin
         model_adv(w, md, e);
         sb_q.push_back(e);
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
      end
   endtask

   task automatic check_entry(input string tag, input logic [63:0] o, input logic d,
                              input logic w, input logic t);
      exp_t e;
      total++;
      assert (sb_q.size() != 0) else begin
         bad++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({tag, "_out"},  o, e.val);
         chk({tag, "_dir"},  {63'd0, d}, {63'd0, e.dir});
         chk({tag, "_wrap"}, {63'd0, w}, {63'd0, e.wrap});
         chk({tag, "_tick"}, {63'd0, t}, 64'd1);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tick8(input string tag, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (tick8 === 1'b1) found = 1'b1;
      end
      total++;
      assert (found) else begin
         bad++;
         $error("FAIL %s_timeout observed=no_tick expected=tick_within_%0d", tag, budget);
      end
   endtask

   task automatic consume8(input string tag, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         wait_tick8(tag, 25);
         check_entry(tag, out8, dir8, wrap8, tick8);
      end
   endtask

   initial begin
      int ticks;

      reset     = 1'b1;
      mode      = 2'b00;
      step      = 1'b0;
      restart   = 1'b0;
      reset_c   = 1'b1;
      mode_c    = 2'b00;
      step_c    = 1'b0;
      restart_c = 1'b0;

      // Reset state and first-advance latency
      clk_n(2);
      chk("rst_out",  out8, 0);
      chk("rst_dir",  dir8, 0);
      chk("rst_tick", tick8, 0);
      chk("rst_wrap", wrap8, 0);
      reset = 1'b0;
      model_reset();
      push_adv(8, 2'b00, 1);
      clk_n(19);
      chk("a_pre_tick", tick8, 0);
      chk("a_pre_out",  out8, 0);
      clk_n(1);
      check_entry("a_first", out8, dir8, wrap8, tick8);

      // Run-wrap up to 233, wrap to 0, then 1
      push_adv(8, 2'b00, 12);
      consume8("a_run", 12);
      chk("a_peak", out8, 233);
      push_adv(8, 2'b00, 1);
      consume8("a_wrap", 1);
      clk_n(1);
      chk("a_wrap_pulse_len", wrap8, 0);
      push_adv(8, 2'b00, 1);
      consume8("a_after_wrap", 1);

      // Full bounce: up to 233, down to 0, turn forward again
      reset = 1'b1;
      mode  = 2'b01;
      clk_n(1);
      reset = 1'b0;
      model_reset();
      push_adv(8, 2'b01, 28);
      consume8("b_bounce", 28);
      chk("b_end_out", out8, 1);

      // Reset while reversing
      reset = 1'b1;
      clk_n(1);
      reset = 1'b0;
      model_reset();
      push_adv(8, 2'b01, 16);
      consume8("b2_bounce", 16);
      chk("b2_dir_rev", dir8, 1);
      reset = 1'b1;
      clk_n(1);
      chk("b2_rst_out", out8, 0);
      chk("b2_rst_dir", dir8, 0);
      reset = 1'b0;
      mode  = 2'b00;
      model_reset();

      // Run to 21, then hold
      push_adv(8, 2'b00, 8);
      consume8("c_run", 8);
      chk("c_at21", out8, 21);
      mode  = 2'b10;
      ticks = 0;
      repeat (100) begin
         @(negedge clk);
         if (tick8 !== 1'b0) ticks++;
      end
      chk("c_hold_ticks", ticks, 0);
      chk("c_hold_out", out8, 21);

      // Single steps
      mode = 2'b11;
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         push_adv(8, 2'b11, 1);
         clk_n(1);
         step = 1'b0;
         check_entry("c_step", out8, dir8, wrap8, tick8);
         clk_n(1);
         chk("c_step_tick_len", tick8, 0);
      end
      chk("c_step_89", out8, 89);

      // Restart beats a simultaneous step
      step    = 1'b1;
      restart = 1'b1;
      clk_n(1);
      step    = 1'b0;
      restart = 1'b0;
      model_reset();
      chk("c_rs_out",  out8, 0);
      chk("c_rs_dir",  dir8, 0);
      chk("c_rs_tick", tick8, 0);
      chk("c_rs_wrap", wrap8, 0);

      // Step held high advances every clock
      step = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push_adv(8, 2'b11, 1);
         clk_n(1);
         check_entry("c_held", out8, dir8, wrap8, tick8);
      end
      step = 1'b0;

      // Back to run-wrap: a full decimation period before the next advance
      mode = 2'b00;
      push_adv(8, 2'b00, 1);
      clk_n(19);
      chk("c_rerun_pre_tick", tick8, 0);
      clk_n(1);
      check_entry("c_rerun", out8, dir8, wrap8, tick8);

      // WIDTH=2, DECIMATION=1
      reset_c = 1'b0;
      model_reset();
      push_adv(2, 2'b00, 6);
      for (int i = 0; i < 6; i++) begin
         clk_n(1);
         check_entry("d_w2", out2, dir2, wrap2, tick2);
      end

      // WIDTH=16, DECIMATION=1
      reset_c = 1'b1;
      clk_n(1);
      chk("d_w16_rst", out16, 0);
      reset_c = 1'b0;
      model_reset();
      push_adv(16, 2'b00, 25);
      for (int i = 0; i < 25; i++) begin
         clk_n(1);
         if (i == 24) chk("d_w16_peak_prev", out16, 0);
         check_entry("d_w16", out16, dir16, wrap16, tick16);
         if (i == 23) chk("d_w16_peak", out16, 46368);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fibo_seq_gen.md
Name: fibo_seq_gen

Overview:
- Parametrised Fibonacci pattern generator for LED and display outputs; the successor to the fixed 8-bit Fibonacci LED block.
- Adds a configurable output width and a programmable decimation rate.
- Adds run modes: wrap, bounce (forward/reverse), hold, and single-step.
- Adds a synchronous restart input and status strobes.
- Sits between the board clock domain and LED/GPIO pins or a downstream display driver.

Parameters:
- WIDTH, 8, output width in bits; legal range 2..32.
- DECIMATION, 20'd1000000, clocks per sequence advance in run modes; legal range ≥1. A value of 1 advances every clock.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- mode  in  2  00 run-wrap, 01 run-bounce, 10 hold, 11 single-step
- step  in  1  advance request; honoured only in mode 11, one advance per clock it is high
- restart  in  1  synchronous return to the start of the sequence
- out  out  WIDTH  current Fibonacci value F(n)
- dir  out  1  0 forward, 1 reverse
- tick  out  1  one-clock pulse, coincident with each change of out caused by an advance
- wrap  out  1  one-clock pulse, coincident with a wrap to 0 or a bounce turnaround

Behaviour:
- Only one clock domain (clk); reset is synchronous and active-high.
- State registers:
  - fa: WIDTH bits; out = fa.
  - fb: WIDTH+1 bits, holding F(n+1).
  - dir.
  - Decimation counter dcnt: width $clog2(DECIMATION), minimum 1 bit.
- Reset: fa=0, fb=1, dir=0, dcnt=0, tick=0, wrap=0.
- Restart: identical effect to reset. Takes priority over any advance in the same cycle; tick=0 and wrap=0 in that cycle.
- Advance condition (adv):
  - Modes 00/01: dcnt==DECIMATION-1. dcnt counts 0..DECIMATION-1 and then wraps to 0.
  - Modes 10/11: dcnt is held at 0.
  - Mode 11: adv = step.
  - Mode 10: adv never asserts.
- Registered outputs: out, dir, tick and wrap update on the clock edge after the cycle in which adv is true. Latency is 1 clock.
- Forward step (dir=0):
  - If fb < 2^WIDTH: (fa,fb) <= (fb, fa+fb). The sum is computed in WIDTH+1 bits and cannot overflow.
  - Else, mode 00 or 11: (fa,fb) <= (0,1); wrap=1.
  - Else, mode 01: dir <= 1 and a reverse step is taken in the same cycle; wrap=1.
- Reverse step (dir=1):
  - If fa != 0: (fa,fb) <= (fb-fa, fa).
  - If fa == 0: dir <= 0 and a forward step is taken in the same cycle, giving (1,1); wrap=1.
- Mode change mid-run:
  - State fa, fb and dir is retained.
  - Entering 10 or 11 clears dcnt the next cycle.
  - Returning to 00 or 01 starts a full DECIMATION period.
  - Entering 00 while dir=1: reverse stepping continues. At fa==0 the block turns forward and then stays forward.
- Mode 11 with step held high: advances every clock.
- WIDTH=8 forward sequence: 0,1,1,2,3,5,8,13,21,34,55,89,144,233, then 0 (wrap).
- WIDTH=8 bounce sequence: ...144,233,144,89,...,2,1,1,0,1,1,2,...
- The first run-mode advance after reset lands DECIMATION clocks after reset is released.
- Outputs are glitch-free registers; the block contains no combinational paths from inputs to outputs.

Decomposition:
- Shared package fibo_pkg:
  - Mode encodings MODE_WRAP=2'b00, MODE_BOUNCE=2'b01, MODE_HOLD=2'b10, MODE_STEP=2'b11.
  - Function clog2_min1.
- Sub-module tick_div: the decimation counter.
  - Parameter DIV.
  - Inputs clk, reset, clr.
  - Output pulse.
  - Reused by other LED pattern blocks.
- The Fibonacci datapath stays in the top module.

Test Plan:
- Reset and basic run: WIDTH=8, DECIMATION=20, mode 00; reset high 2 clk then low → out=0; first tick 20 clk after release; out=1; after 13 ticks out=233.
- Wrap: continue from 233 → next tick gives out=0, wrap=1 for one clock, dir=0; the following tick gives out=1.
- Bounce: mode 01 from reset; at out=233 the next tick gives out=144, dir=1, wrap=1. Continue to out=0, then the next tick gives out=1, dir=0, wrap=1.
- Hold and step:
  - Run to out=21, switch to mode 10 for 100 clk → out stays 21, tick stays 0.
  - Switch to mode 11 and pulse step 3 times → out=34, 55, 89, each with one tick.
- Restart priority: in mode 11 assert step and restart in the same clock at out=89 → out=0, dir=0, tick=0, wrap=0. Assert reset mid-bounce (dir=1) → out=0, dir=0.
- Corner parameters:
  - DECIMATION=1: an advance every clock.
  - WIDTH=2: sequence 0,1,1,2,3, then 0.
  - WIDTH=16: max out 46368, then wrap.
